// File: rtl/kf8237_channel_arbiter_if.sv
// Signal bundle between the KF8237 channel arbiter and its register, CPU-hold and timing neighbours.
// The master modport is the arbiter's view and the slave modport is the surrounding logic's view.
interface kf8237_channel_arbiter_if #(
  parameter int CHANNELS = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0] dma_request;
  logic                dreq_sense_low;
  logic                dack_sense_high;
  logic                rotating_priority;
  logic                controller_disable;
  logic [CHANNELS-1:0] mask_register;
  logic [CHANNELS-1:0] request_register;
  logic                hold_acknowledge;
  logic                transfer_end;
  logic                hold_request;
  logic [CHANNELS-1:0] dma_acknowledge;
  logic [CW-1:0]       active_channel;
  logic                grant_valid;
  logic [CHANNELS-1:0] request_status;

  modport master (
    input  dma_request, dreq_sense_low, dack_sense_high, rotating_priority,
    input  controller_disable, mask_register, request_register,
    input  hold_acknowledge, transfer_end,
    output hold_request, dma_acknowledge, active_channel, grant_valid, request_status
  );

  modport slave (
    output dma_request, dreq_sense_low, dack_sense_high, rotating_priority,
    output controller_disable, mask_register, request_register,
    output hold_acknowledge, transfer_end,
    input  hold_request, dma_acknowledge, active_channel, grant_valid, request_status
  );
endinterface

// File: rtl/kf8237_channel_arbiter.sv
// KF8237 DMA channel arbiter: fixed/rotating priority, HRQ/HLDA hold sequencing and DACK drive.
// Optional macro KF8237_ARBITER_SYNC_EN adds a second DREQ flop as a metastability synchroniser.
module kf8237_channel_arbiter #(
  parameter int CHANNELS = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  kf8237_channel_arbiter_if.master      bus,
  output logic [1:0]                    fsm_state_o
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HOLD_WAIT = 2'd1;
  localparam logic [1:0] ST_SERVICE   = 2'd2;
  localparam logic [1:0] ST_RELEASE   = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                hrq_q, hrq_d;
  logic                grant_q, grant_d;
  logic [CW-1:0]       active_q, active_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic [CHANNELS-1:0] dreq_q;
  logic [CHANNELS-1:0] request_status_q;
  logic [CHANNELS-1:0] eff_req;
  logic [CW-1:0]       winner;

  // DREQ samples are stored already normalised to active-high, so reset value 0 means inactive.
`ifdef KF8237_ARBITER_SYNC_EN
  logic [CHANNELS-1:0] dreq_meta_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dreq_meta_q <= '0;
      dreq_q      <= '0;
    end else begin
      dreq_meta_q <= bus.dma_request ^ {CHANNELS{bus.dreq_sense_low}};
      dreq_q      <= dreq_meta_q;
    end
  end
`else
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) dreq_q <= '0;
    else          dreq_q <= bus.dma_request ^ {CHANNELS{bus.dreq_sense_low}};
  end
`endif

  assign eff_req = (dreq_q & ~bus.mask_register) | bus.request_register;

  function automatic logic [CW-1:0] pick_winner(input logic [CHANNELS-1:0] req,
                                                input logic [CW-1:0] start);
    logic found;
    int   idx;
    pick_winner = '0;
    found       = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(start) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!found && req[idx]) begin
        pick_winner = CW'(idx);
        found       = 1'b1;
      end
    end
  endfunction

  assign winner = pick_winner(eff_req, bus.rotating_priority ? ptr_q : '0);

  // Handshake: HRQ rises one clock after a winning request and holds until the service ends or
  // every request is withdrawn; HLDA is sampled only on clock edges, DACK follows it by one clock,
  // and a new HRQ is not raised until HLDA has dropped after a completed service.
  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    grant_d  = grant_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|eff_req && !bus.controller_disable) begin
          active_d = winner;
          hrq_d    = 1'b1;
          state_d  = ST_HOLD_WAIT;
        end
      end
      ST_HOLD_WAIT: begin
        if (eff_req == '0) begin
          hrq_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (bus.hold_acknowledge) begin
          active_d = winner;
          grant_d  = 1'b1;
          state_d  = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (bus.transfer_end) begin
          grant_d = 1'b0;
          hrq_d   = 1'b0;
          if (bus.rotating_priority)
            ptr_d = (active_q == CW'(CHANNELS - 1)) ? '0 : active_q + CW'(1);
          state_d = ST_RELEASE;
        end else if (!bus.hold_acknowledge) begin
          grant_d = 1'b0;
          hrq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (!bus.hold_acknowledge) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      hrq_q            <= 1'b0;
      grant_q          <= 1'b0;
      active_q         <= '0;
      ptr_q            <= '0;
      request_status_q <= '0;
    end else begin
      state_q          <= state_d;
      hrq_q            <= hrq_d;
      grant_q          <= grant_d;
      active_q         <= active_d;
      ptr_q            <= ptr_d;
      request_status_q <= eff_req;
    end
  end

  always_comb begin
    bus.dma_acknowledge = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.dma_acknowledge[i] = (grant_q && active_q == CW'(i)) ? bus.dack_sense_high
                                                               : ~bus.dack_sense_high;
    end
  end

  assign bus.hold_request   = hrq_q;
  assign bus.grant_valid    = grant_q;
  assign bus.active_channel = active_q;
  assign bus.request_status = request_status_q;
  assign fsm_state_o        = state_q;
endmodule

// File: tb/tb_kf8237_channel_arbiter.sv
// Bench for kf8237_channel_arbiter: directed scenarios then randomized traffic, all checked
// against a behavioural arbitration model and a grant-order scoreboard.
module tb_kf8237_channel_arbiter;
  localparam int N  = 4;
  localparam int CW = 2;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  kf8237_channel_arbiter_if #(.CHANNELS(N)) bus ();
  logic [1:0] fsm_state;

  kf8237_channel_arbiter #(.CHANNELS(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .fsm_state_o (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  logic [N-1:0]  m_meta, m_dreq, m_status;
  bit            m_hrq, m_release;
  int            m_grant;
  logic [CW-1:0] m_active;
  int            m_ptr;
  logic [CW-1:0] exp_q[$];
  bit            prev_gv;

  function automatic int pick(input logic [N-1:0] req, input int start);
    int best, best_rank, rank;
    best = -1;
    best_rank = N;
    for (int c = 0; c < N; c++) begin
      rank = (c - start + N) % N;
      if (req[c] && rank < best_rank) begin
        best = c;
        best_rank = rank;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_meta = '0; m_dreq = '0; m_status = '0;
    m_hrq = 0; m_release = 0; m_grant = -1; m_active = '0; m_ptr = 0;
    exp_q.delete();
    prev_gv = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] eff;
    int start, w;
    eff   = (m_dreq & ~bus.mask_register) | bus.request_register;
    start = bus.rotating_priority ? m_ptr : 0;
    if (m_release) begin
      if (!bus.hold_acknowledge) m_release = 0;
    end else if (m_grant >= 0) begin
      if (bus.transfer_end) begin
        if (bus.rotating_priority) m_ptr = (m_grant + 1) % N;
        m_grant = -1; m_hrq = 0; m_release = 1;
      end else if (!bus.hold_acknowledge) begin
        m_grant = -1; m_hrq = 0;
      end
    end else if (m_hrq) begin
      if (eff == '0) m_hrq = 0;
      else if (bus.hold_acknowledge) begin
        w = pick(eff, start);
        m_grant = w; m_active = CW'(w);
        exp_q.push_back(CW'(w));
      end
    end else if (eff != '0 && !bus.controller_disable) begin
      w = pick(eff, start);
      m_active = CW'(w); m_hrq = 1;
    end
    m_status = eff;
`ifdef KF8237_ARBITER_SYNC_EN
    m_dreq = m_meta;
    m_meta = bus.dma_request ^ {N{bus.dreq_sense_low}};
`else
    m_dreq = bus.dma_request ^ {N{bus.dreq_sense_low}};
`endif
  endtask

  function automatic logic [N-1:0] exp_dack();
    logic [N-1:0] d;
    for (int c = 0; c < N; c++) d[c] = (m_grant == c) ? bus.dack_sense_high : ~bus.dack_sense_high;
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    logic [CW-1:0] e;
    chk("hold_request", 32'(bus.hold_request), 32'(m_hrq));
    chk("grant_valid", 32'(bus.grant_valid), 32'(m_grant >= 0));
    chk("active_channel", 32'(bus.active_channel), 32'(m_active));
    chk("request_status", 32'(bus.request_status), 32'(m_status));
    chk("dma_acknowledge", 32'(bus.dma_acknowledge), 32'(exp_dack()));
    if (bus.grant_valid && !prev_gv) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL sb_grant observed=ch%0d expected=no_grant", bus.active_channel);
      end else begin
        e = exp_q.pop_front();
        chk("sb_grant", 32'(bus.active_channel), 32'(e));
      end
    end
    prev_gv = bus.grant_valid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
    model_step();
    check_all();
  endtask

  task automatic sync_extra();
`ifdef KF8237_ARBITER_SYNC_EN
    tick();
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic clear_inputs();
    bus.dma_request = '0; bus.dreq_sense_low = 0; bus.dack_sense_high = 1;
    bus.rotating_priority = 0; bus.controller_disable = 0; bus.mask_register = '0;
    bus.request_register = '0; bus.hold_acknowledge = 0; bus.transfer_end = 0;
  endtask

  task automatic finish_service();
    bus.dma_request = '0;
    bus.transfer_end = 1;
    tick();
    bus.transfer_end = 0;
    chk("end_dack_off", 32'(bus.dma_acknowledge), 32'h0);
    chk("end_hrq_off", 32'(bus.hold_request), 32'h0);
    bus.hold_acknowledge = 0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    do_reset();
    chk("reset_hrq", 32'(bus.hold_request), 32'h0);
    chk("reset_dack", 32'(bus.dma_acknowledge), 32'h0);

    // Fixed priority: DREQ 1010 -> ch1, HRQ two clocks after the pin
    bus.dma_request = 4'b1010;
    tick();
    sync_extra();
    chk("t1_hrq_early", 32'(bus.hold_request), 32'h0);
    tick();
    chk("t1_hrq_up", 32'(bus.hold_request), 32'h1);
    bus.hold_acknowledge = 1;
    tick();
    chk("t1_dack", 32'(bus.dma_acknowledge), 32'b0010);
    chk("t1_active", 32'(bus.active_channel), 32'h1);
    finish_service();

    // Rotating: after ch1 the order is 2,3,0,1 so 0011 grants ch0
    bus.rotating_priority = 1;
    bus.dma_request = 4'b0010;
    tick(); tick(); sync_extra();
    bus.hold_acknowledge = 1;
    tick();
    chk("t2_first", 32'(bus.active_channel), 32'h1);
    finish_service();
    bus.dma_request = 4'b0011;
    tick(); tick(); sync_extra();
    chk("t2_hrq", 32'(bus.hold_request), 32'h1);
    bus.hold_acknowledge = 1;
    tick();
    chk("t2_dack", 32'(bus.dma_acknowledge), 32'b0001);
    finish_service();

    // Withdrawal before HLDA
    bus.rotating_priority = 0;
    bus.dma_request = 4'b0100;
    tick(); tick(); tick(); sync_extra();
    chk("t3_hrq_up", 32'(bus.hold_request), 32'h1);
    bus.dma_request = '0;
    tick(); sync_extra();
    chk("t3_hrq_hold", 32'(bus.hold_request), 32'h1);
    tick();
    chk("t3_hrq_drop", 32'(bus.hold_request), 32'h0);
    chk("t3_no_dack", 32'(bus.dma_acknowledge), 32'h0);

    // Late higher-priority request wins at the HLDA edge
    bus.dma_request = 4'b1000;
    tick(); tick(); sync_extra();
    chk("t4_first_winner", 32'(bus.active_channel), 32'h3);
    bus.dma_request = 4'b1001;
    tick(); sync_extra();
    bus.hold_acknowledge = 1;
    tick();
    chk("t4_dack", 32'(bus.dma_acknowledge), 32'b0001);
    finish_service();

    // Abort leaves the rotating pointer alone (still 1 after ch0 service)
    bus.rotating_priority = 1;
    bus.dma_request = 4'b0100;
    tick(); tick(); sync_extra();
    bus.hold_acknowledge = 1;
    tick();
    chk("t5_grant_ch2", 32'(bus.active_channel), 32'h2);
    bus.hold_acknowledge = 0;
    bus.dma_request = '0;
    tick();
    chk("t5_abort_dack", 32'(bus.dma_acknowledge), 32'h0);
    tick();
    bus.dma_request = 4'b0011;
    tick(); tick(); sync_extra();
    bus.hold_acknowledge = 1;
    tick();
    chk("t5_ptr_kept", 32'(bus.active_channel), 32'h1);
    #2;
    clear_inputs();
    bus.rotating_priority = 1;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_hrq", 32'(bus.hold_request), 32'h0);
    chk("t5_rst_dack", 32'(bus.dma_acknowledge), 32'h0);
    chk("t5_rst_gv", 32'(bus.grant_valid), 32'h0);
    do_reset();

    // Sense polarity, mask and software request
    bus.dreq_sense_low = 1; bus.dack_sense_high = 1;
    bus.mask_register = 4'b0001; bus.request_register = 4'b0001;
    bus.dma_request = 4'b1111;
    tick();
    chk("t6_sw_hrq", 32'(bus.hold_request), 32'h1);
    bus.hold_acknowledge = 1;
    tick();
    chk("t6_dack", 32'(bus.dma_acknowledge), 32'b0001);
    bus.dack_sense_high = 0;
    #1;
    chk("t6_dack_low", 32'(bus.dma_acknowledge), 32'b1110);
    bus.dack_sense_high = 1;
    bus.request_register = '0;
    bus.transfer_end = 1;
    tick();
    bus.transfer_end = 0;
    bus.hold_acknowledge = 0;
    tick();
    bus.dma_request = 4'b1110;
    repeat (4) tick();
    chk("t6_masked", 32'(bus.hold_request), 32'h0);
    clear_inputs();
    tick(); tick();

    // Randomized traffic
    for (int cyc = 0; cyc < 600; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus.dma_request = N'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.mask_register = N'($urandom_range(0, 15));
      bus.request_register = ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 39) == 0) bus.rotating_priority = ~bus.rotating_priority;
      bus.controller_disable = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) bus.dreq_sense_low = ~bus.dreq_sense_low;
      if ($urandom_range(0, 49) == 0) bus.dack_sense_high = ~bus.dack_sense_high;
      if (m_hrq && !bus.hold_acknowledge) bus.hold_acknowledge = ($urandom_range(0, 1) == 1);
      else if (!m_hrq && bus.hold_acknowledge) bus.hold_acknowledge = ($urandom_range(0, 1) == 1);
      else if (m_grant >= 0 && $urandom_range(0, 19) == 0) bus.hold_acknowledge = 0;
      bus.transfer_end = (m_grant >= 0) && ($urandom_range(0, 3) == 0);
      tick();
    end

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
